// File: rtl/csr_enc_deadlock_report_ctrl.sv
// csr_enc deadlock report scheduler: round-robin scan, confirm, report, sticky hold.
// Optional CSR_ENC_DEADLOCK_TS_EN adds a free-running timestamp captured on confirm.
module csr_enc_deadlock_report_ctrl #(
  parameter int NUM_MON = 4,
  parameter int CNT_W   = 16,
  parameter int THRESH  = 1000,
`ifdef CSR_ENC_DEADLOCK_TS_EN
  parameter int TS_W    = 32,
`endif
  localparam int IDX_W  = $clog2(NUM_MON)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [NUM_MON-1:0] report_snap,
  output logic               deadlock,
`ifdef CSR_ENC_DEADLOCK_TS_EN
  output logic [TS_W-1:0]    report_ts,
`endif
  output logic [IDX_W-1:0]   scan_ptr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_CONFIRM,
    S_REPORT,
    S_HOLD
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   ridx_d;
  logic [NUM_MON-1:0] snap_d;
  logic               cap;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_MON-1)) ? '0 : i + IDX_W'(1);
  endfunction

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    idx_d   = idx;
    cnt_d   = cnt;
    ridx_d  = report_idx;
    snap_d  = report_snap;
    cap     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (mon_block[ptr]) begin
          idx_d   = ptr;
          cnt_d   = CNT_W'(1);
          state_d = S_CONFIRM;
        end else begin
          ptr_d = wrap_inc(ptr);
        end
      end
      S_CONFIRM: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (mon_block[idx]) begin
          if (cnt == CNT_W'(THRESH-1)) begin
            ridx_d  = idx;
            snap_d  = mon_block;
            cap     = 1'b1;
            cnt_d   = '0;
            state_d = S_REPORT;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else begin
          // resume after the dropped candidate so it cannot starve others
          cnt_d   = '0;
          ptr_d   = wrap_inc(idx);
          state_d = S_SCAN;
        end
      end
      S_REPORT: begin
        if (report_ready) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (clear) begin
          ptr_d   = wrap_inc(idx);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      idx         <= '0;
      cnt         <= '0;
      report_idx  <= '0;
      report_snap <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      report_idx  <= ridx_d;
      report_snap <= snap_d;
    end
  end

`ifdef CSR_ENC_DEADLOCK_TS_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q      <= '0;
      report_ts <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (cap) report_ts <= ts_q;
    end
  end
`else
  logic unused_cap;
  assign unused_cap = cap;
`endif

  assign report_valid = (state == S_REPORT);
  assign deadlock     = (state == S_HOLD);
  assign scan_ptr     = ptr;

endmodule

// File: tb/tb_csr_enc_deadlock_report_ctrl.sv
// Bench for csr_enc_deadlock_report_ctrl: vector table, directed corners, random vs model.
// Build with CSR_ENC_DEADLOCK_TS_EN to also check report_ts.
module tb_csr_enc_deadlock_report_ctrl;

  localparam int N  = 4;
  localparam int TH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] mon_block;
  logic       clear;
  logic       report_valid;
  logic       report_ready;
  logic [1:0] report_idx;
  logic [3:0] report_snap;
  logic       deadlock;
  logic [1:0] scan_ptr;
`ifdef CSR_ENC_DEADLOCK_TS_EN
  logic [31:0] report_ts;
`endif

  csr_enc_deadlock_report_ctrl #(
    .NUM_MON(N),
    .CNT_W(16),
    .THRESH(TH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .mon_block(mon_block),
    .clear(clear),
    .report_valid(report_valid),
    .report_ready(report_ready),
    .report_idx(report_idx),
    .report_snap(report_snap),
    .deadlock(deadlock),
`ifdef CSR_ENC_DEADLOCK_TS_EN
    .report_ts(report_ts),
`endif
    .scan_ptr(scan_ptr)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: modes and a count of consecutive blocked samples
  localparam int M_IDLE = 0, M_SCAN = 1, M_CONF = 2, M_REP = 3, M_HOLD = 4;
  int         m_mode, m_ptr, m_cand, m_run, m_ridx;
  logic [3:0] m_snap;
  int unsigned m_ts, m_rts;

  task automatic model_reset();
    m_mode = M_IDLE; m_ptr = 0; m_cand = 0; m_run = 0;
    m_ridx = 0; m_snap = '0; m_ts = 0; m_rts = 0;
  endtask

  task automatic model_step();
    case (m_mode)
      M_IDLE: if (enable) m_mode = M_SCAN;
      M_SCAN: begin
        if (!enable) m_mode = M_IDLE;
        else if (mon_block[m_ptr]) begin
          m_cand = m_ptr; m_run = 1; m_mode = M_CONF;
        end else m_ptr = (m_ptr + 1) % N;
      end
      M_CONF: begin
        if (!enable) begin
          m_run = 0; m_mode = M_IDLE;
        end else if (mon_block[m_cand]) begin
          m_run++;
          if (m_run == TH) begin
            m_ridx = m_cand; m_snap = mon_block; m_rts = m_ts; m_mode = M_REP;
          end
        end else begin
          m_run = 0; m_ptr = (m_cand + 1) % N; m_mode = M_SCAN;
        end
      end
      M_REP: if (report_ready) m_mode = M_HOLD;
      M_HOLD: if (clear) begin
        m_ptr = (m_cand + 1) % N; m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    m_ts++;
  endtask

  task automatic check(string name);
    logic ok;
    n_vec++;
    ok = (report_valid == (m_mode == M_REP)) && (deadlock == (m_mode == M_HOLD))
      && (scan_ptr == 2'(m_ptr)) && (report_idx == 2'(m_ridx)) && (report_snap == m_snap);
`ifdef CSR_ENC_DEADLOCK_TS_EN
    ok = ok && (report_ts == m_rts);
`endif
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got v=%0b dl=%0b ptr=%0d idx=%0d snap=%b, want v=%0b dl=%0b ptr=%0d idx=%0d snap=%b",
        name, report_valid, deadlock, scan_ptr, report_idx, report_snap,
        m_mode == M_REP, m_mode == M_HOLD, m_ptr, m_ridx, m_snap);
    end
  endtask

  task automatic expect_eq(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(string name);
    @(posedge clock);
    model_step();
    #1;
    check(name);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(posedge clock);
    #1;
    check("reset_held");
    reset = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] mon;
    logic       clr;
    logic       rdy;
    logic       ev;
    logic [1:0] eidx;
    logic [3:0] esnap;
    logic       edl;
    logic [1:0] eptr;
  } vec_t;

  vec_t tbl[24];

  initial begin
    tbl[0]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd1};
    tbl[2]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2};
    tbl[3]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2};
    tbl[4]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2};
    tbl[5]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2};
    tbl[6]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 2'd2};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 2'd2};
    tbl[8]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 2'd2};
    tbl[9]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 2'd2};
    tbl[10] = '{1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 2'd2};
    tbl[11] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 2'd2};
    tbl[12] = '{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd3};
    tbl[13] = '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd3};
    tbl[14] = '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd3};
    tbl[15] = '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd3};
    tbl[16] = '{1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd3};
    tbl[17] = '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd3};
    tbl[18] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd0};
    tbl[19] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd1};
    tbl[20] = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd1};
    tbl[21] = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd1};
    tbl[22] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd2};
    tbl[23] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 2'd3};

    enable = 1'b0; mon_block = '0; clear = 1'b0; report_ready = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check("power_on_reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      logic ok;
      enable = tbl[i].en; mon_block = tbl[i].mon;
      clear = tbl[i].clr; report_ready = tbl[i].rdy;
      step($sformatf("tbl_model_%0d", i));
      n_vec++;
      ok = (report_valid == tbl[i].ev) && (report_idx == tbl[i].eidx)
        && (report_snap == tbl[i].esnap) && (deadlock == tbl[i].edl)
        && (scan_ptr == tbl[i].eptr);
      if (!ok) begin
        n_bad++;
        $display("FAIL tbl_%0d: got v=%0b idx=%0d snap=%b dl=%0b ptr=%0d, want v=%0b idx=%0d snap=%b dl=%0b ptr=%0d",
          i, report_valid, report_idx, report_snap, deadlock, scan_ptr,
          tbl[i].ev, tbl[i].eidx, tbl[i].esnap, tbl[i].edl, tbl[i].eptr);
      end
    end

    // asynchronous reset mid-run with everything asserted
    enable = 1'b1; mon_block = 4'b1111; clear = 1'b1; report_ready = 1'b1;
    step("pre_reset");
    do_reset();
    expect_eq("reset_ptr", int'(scan_ptr), 0);
    enable = 1'b0; mon_block = '0; clear = 1'b0; report_ready = 1'b0;
    step("post_reset_idle");
    expect_eq("post_reset_valid", int'(report_valid), 0);

`ifdef CSR_ENC_DEADLOCK_TS_EN
    // timestamp: hit at ptr 2 in cycle t, report_ts equals counter at t+3
    begin
      int unsigned t_hit;
      bit seen;
      enable = 1'b1; mon_block = 4'b0100;
      seen = 0;
      t_hit = 0;
      for (int k = 0; k < 20 && !report_valid; k++) begin
        if (!seen && m_mode == M_SCAN && m_ptr == 2) begin
          seen = 1; t_hit = m_ts;
        end
        step("ts_wait");
      end
      expect_eq("ts_valid", int'(report_valid), 1);
      expect_eq("ts_value", int'(report_ts), int'(t_hit + 3));
      report_ready = 1'b1; step("ts_ack");
      report_ready = 1'b0; clear = 1'b1; step("ts_clear");
      clear = 1'b0; enable = 1'b0;
      do_reset();
    end
`endif

    // two blocked monitors: fairness moves on from idx 1 to idx 3
    enable = 1'b1; mon_block = 4'b1010;
    for (int k = 0; k < 20 && !report_valid; k++) step("fair_wait1");
    expect_eq("fair_valid1", int'(report_valid), 1);
    expect_eq("fair_idx1", int'(report_idx), 1);
    report_ready = 1'b1; step("fair_ack1");
    expect_eq("fair_deadlock", int'(deadlock), 1);
    report_ready = 1'b0; step("fair_hold");
    clear = 1'b1; step("fair_clear");
    expect_eq("fair_cleared", int'(deadlock), 0);
    clear = 1'b0;
    for (int k = 0; k < 20 && !report_valid; k++) step("fair_wait2");
    expect_eq("fair_valid2", int'(report_valid), 1);
    expect_eq("fair_idx2", int'(report_idx), 3);
    report_ready = 1'b1; step("fair_ack2");
    report_ready = 1'b0; clear = 1'b1; step("fair_clear2");
    clear = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) mon_block = 4'($urandom);
      enable       = ($urandom_range(0, 19) != 0);
      report_ready = ($urandom_range(0, 2) == 0);
      clear        = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
